// File: rtl/gate_result_checker_if.sv
// Event-FIFO head handshake between the checker and its consumer.
// valid/ready: the head is transferred on a rising edge where out_valid and out_ready are both 1;
// out_data/out_err are held stable while out_valid=1 and out_ready=0.
interface gate_result_checker_if;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic       out_err;

  modport master (
    output out_valid,
    output out_data,
    output out_err,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_err,
    output out_ready
  );
endinterface

// File: rtl/gate_result_checker.sv
// Watches an AND stage and logs every change of {a,b,c} into a small FIFO.
// Each logged entry carries a mismatch bit (c != a&b).
module gate_result_checker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_a,
  input  logic                   in_b,
  input  logic                   in_c,
  input  logic                   smp_en,
  gate_result_checker_if.master  evt_if,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [CNT_W-1:0]       evt_cnt,
  output logic                   overflow
);

  localparam int            AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] C_SAT = {CNT_W{1'b1}};

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("gate_result_checker: DEPTH must be a power of two in 2..16");
  end

  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic [3:0]       r_mem [DEPTH];
  logic [2:0]       r_prev;
  logic             r_arm;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_evt_cnt;
  logic             r_overflow;

  logic [2:0]       w_sample;
  logic             w_mis;
  logic             w_evt;
  logic             w_valid;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [3:0]       w_head;

  assign w_sample = {in_a, in_b, in_c};
  assign w_mis    = in_c ^ (in_a & in_b);
  assign w_evt    = smp_en & (r_arm | (w_sample != r_prev));

  assign w_valid  = (r_count != '0);
  assign w_full   = (r_count == C_FULL);
  assign w_pop    = w_valid & evt_if.out_ready;
  // A full FIFO still accepts the event when the head leaves on the same edge.
  assign w_push   = w_evt & (~w_full | w_pop);
  assign w_drop   = w_evt & ~w_push;

  assign w_head   = r_mem[r_rd_ptr];

  // Outputs depend only on registered state, so inputs never reach them combinationally.
  assign evt_if.out_valid = w_valid;
  assign evt_if.out_data  = w_valid ? w_head[3:1] : 3'b000;
  assign evt_if.out_err   = w_valid ? w_head[0]   : 1'b0;
  assign err_cnt          = r_err_cnt;
  assign evt_cnt          = r_evt_cnt;
  assign overflow         = r_overflow;

  // Sample tracking: arm re-opens the monitor whenever sampling is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 3'b000;
      r_arm  <= 1'b1;
    end else if (!smp_en) begin
      r_arm  <= 1'b1;
    end else begin
      r_prev <= w_sample;
      if (w_evt) begin
        r_arm <= 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while occupancy covers them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_sample, w_mis};
    end
  end

  // Statistics: dropped events still count as errors but not as logged events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt  <= '0;
      r_evt_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_evt && w_mis && (r_err_cnt != C_SAT)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      if (w_push && (r_evt_cnt != C_SAT)) begin
        r_evt_cnt <= r_evt_cnt + CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gate_result_checker.sv
// Directed bench for gate_result_checker (DEPTH=4, CNT_W=8).
module tb_gate_result_checker;

  logic       clk;
  logic       rst_n;
  logic       in_a;
  logic       in_b;
  logic       in_c;
  logic       smp_en;
  logic [7:0] err_cnt;
  logic [7:0] evt_cnt;
  logic       overflow;

  int total_cnt;
  int bad_cnt;

  gate_result_checker_if bus ();

  gate_result_checker #(
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_c     (in_c),
    .smp_en   (smp_en),
    .evt_if   (bus),
    .err_cnt  (err_cnt),
    .evt_cnt  (evt_cnt),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_head(input string tag, input logic v, input logic [2:0] d, input logic e);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".data"},  32'(bus.out_data),  32'(d));
    check({tag, ".err"},   32'(bus.out_err),   32'(e));
  endtask

  task automatic check_cnt(input string tag, input logic [7:0] evt, input logic [7:0] err,
                           input logic ovf);
    check({tag, ".evt_cnt"},  32'(evt_cnt),  32'(evt));
    check({tag, ".err_cnt"},  32'(err_cnt),  32'(err));
    check({tag, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask

  task automatic set_in(input logic [2:0] v);
    {in_a, in_b, in_c} = v;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [2:0] walk   [4];
  logic [2:0] chg    [6];
  logic [2:0] drn_d  [4];
  logic       drn_e  [4];

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    walk  = '{3'b000, 3'b010, 3'b100, 3'b111};
    chg   = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b111};
    drn_d = '{3'b000, 3'b001, 3'b010, 3'b100};
    drn_e = '{1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    smp_en = 1'b0;
    set_in(3'b000);
    bus.out_ready = 1'b0;
    repeat (2) tick();
    check_head("reset", 1'b0, 3'b000, 1'b0);
    check_cnt("reset", 8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;

    // Held input logs once and the head stays stable while not accepted.
    smp_en = 1'b1;
    set_in(3'b010);
    repeat (5) begin
      tick();
      check_head("hold", 1'b1, 3'b010, 1'b0);
    end
    check_cnt("hold", 8'd1, 8'd0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_head("hold_pop", 1'b0, 3'b000, 1'b0);

    // Walk of good gate values with a consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(walk[i]);
      tick();
      check_head("walk", 1'b1, walk[i], 1'b0);
    end
    tick();
    check_head("walk_end", 1'b0, 3'b000, 1'b0);
    check_cnt("walk", 8'd5, 8'd0, 1'b0);
    bus.out_ready = 1'b0;

    // Faulty gate outputs.
    set_in(3'b110);
    tick();
    set_in(3'b011);
    tick();
    check_cnt("fault", 8'd7, 8'd2, 1'b0);
    check_head("fault0", 1'b1, 3'b110, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_head("fault1", 1'b1, 3'b011, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_head("fault_end", 1'b0, 3'b000, 1'b0);

    // Six changes into a 4-deep FIFO; last two dropped (101 is a mismatch).
    for (int i = 0; i < 6; i++) begin
      set_in(chg[i]);
      tick();
    end
    check_cnt("ovf", 8'd11, 8'd4, 1'b1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head("drain", 1'b1, drn_d[i], drn_e[i]);
      tick();
    end
    check_head("drain_end", 1'b0, 3'b000, 1'b0);
    bus.out_ready = 1'b0;

    // Reset mid-operation with three entries queued.
    set_in(3'b000);
    tick();
    set_in(3'b010);
    tick();
    set_in(3'b110);
    tick();
    check_cnt("pre_rst", 8'd14, 8'd5, 1'b1);
    check_head("pre_rst", 1'b1, 3'b000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_head("async_rst", 1'b0, 3'b000, 1'b0);
    check_cnt("async_rst", 8'd0, 8'd0, 1'b0);
    set_in(3'b011);
    tick();
    set_in(3'b111);
    tick();
    check_head("in_rst", 1'b0, 3'b000, 1'b0);
    check_cnt("in_rst", 8'd0, 8'd0, 1'b0);
    set_in(3'b101);
    rst_n = 1'b1;
    tick();
    check_head("post_rst", 1'b1, 3'b101, 1'b1);
    check_cnt("post_rst", 8'd1, 8'd1, 1'b0);

    // Fill to four, then push and pop on the same edge while full.
    set_in(3'b000);
    tick();
    set_in(3'b011);
    tick();
    set_in(3'b110);
    tick();
    check_cnt("full", 8'd4, 8'd3, 1'b0);
    check_head("full", 1'b1, 3'b101, 1'b1);
    bus.out_ready = 1'b1;
    set_in(3'b111);
    tick();
    check_cnt("full_pp", 8'd5, 8'd3, 1'b0);
    check_head("full_pp", 1'b1, 3'b000, 1'b0);
    tick();
    check_head("full_d1", 1'b1, 3'b011, 1'b1);
    tick();
    check_head("full_d2", 1'b1, 3'b110, 1'b1);
    tick();
    check_head("full_d3", 1'b1, 3'b111, 1'b0);
    tick();
    check_head("full_end", 1'b0, 3'b000, 1'b0);
    check_cnt("final", 8'd5, 8'd3, 1'b0);
    bus.out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/gate_result_checker.md
GATE_RESULT_CHECKER -- requirements
Module: gate_result_checker

Interface
REQ-001 Parameter DEPTH, default 4, sets the event FIFO depth in entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter CNT_W, default 8, sets the width of the error and event counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous reset, active-low; applies immediately and releases synchronously to clk.
REQ-005 in_a, in_b  input  1 each  operands driven into the observed AND stage.
REQ-006 in_c  input  1  result produced by the observed AND stage.
REQ-007 smp_en  input  1  when high, the block samples the observed signals on each clock.
REQ-008 out_valid  output  1  the FIFO head entry is valid.
REQ-009 out_ready  input  1  the consumer accepts the head entry.
REQ-010 out_data  output  3  head entry as {a,b,c}.
REQ-011 out_err  output  1  head entry failed the check (c != a&b).
REQ-012 err_cnt  output  CNT_W  count of mismatching samples logged.
REQ-013 evt_cnt  output  CNT_W  count of events pushed into the FIFO.
REQ-014 overflow  output  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-015 An event is generated on a rising edge when smp_en=1 and either the arm flag is set or {in_a,in_b,in_c} differs from the stored previous sample; this is the hardware equivalent of $monitor semantics.
REQ-016 The arm flag is set by reset and on every cycle with smp_en=0; it is cleared by the first event, so the first sample after reset or after re-enable is always logged.
REQ-017 The previous sample register loads {in_a,in_b,in_c} on every edge with smp_en=1, whether or not the event was stored.
REQ-018 The mismatch bit for an event is in_c XOR (in_a AND in_b), evaluated on the same edge.
REQ-019 An event is pushed as {a,b,c,mismatch} when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-020 A pop occurs when out_valid=1 and out_ready=1.
REQ-021 Latency: an event pushed at edge k into an empty FIFO appears with out_valid=1 after edge k; there is no combinational path from the inputs to the outputs.
REQ-022 Ordering is strictly FIFO; read and write pointers wrap modulo DEPTH; occupancy is tracked in a log2(DEPTH)+1-bit count.
REQ-023 When the FIFO is empty, out_valid=0 and out_data/out_err hold 0; a pop attempt while empty has no effect.
REQ-024 A dropped event (FIFO full, no pop) sets overflow, and overflow stays at 1 until reset.
REQ-025 A dropped event still increments err_cnt if it mismatched, but it does not increment evt_cnt.
REQ-026 err_cnt and evt_cnt saturate at 2^CNT_W-1 and never wrap.
REQ-027 Simultaneous push and pop leave occupancy unchanged; with DEPTH=1 entry remaining, push and pop on the same edge are both honoured.
REQ-028 out_data and out_err change only after a pop or after a push into an empty FIFO; they are held stable while out_valid=1 and out_ready=0.

Reset
REQ-029 When rst_n=0, the following apply asynchronously: out_valid=0, out_data=0, out_err=0, err_cnt=0, evt_cnt=0, overflow=0, pointers=0, occupancy=0, previous sample=0, arm=1.
REQ-030 A reset mid-operation discards all FIFO contents; the first smp_en=1 edge after release logs an event.
REQ-031 Inputs are ignored while rst_n=0.

Verification
REQ-032 Bench scenario: with rst_n released, smp_en=1 and {a,b,c}=010 held for 5 cycles -> exactly one entry out_data=010, out_err=0, evt_cnt=1.
REQ-033 Bench scenario: walk 000,010,100,111 one per cycle with out_ready=1 -> 4 entries in order, all out_err=0, err_cnt=0.
REQ-034 Bench scenario: inject a faulty gate ({1,1,0} then {0,1,1}) -> out_err=1 on both entries, err_cnt=2.
REQ-035 Bench scenario: DEPTH=4, out_ready=0, 6 distinct changes -> 4 entries stored, overflow=1, evt_cnt=4; drain returns the first 4 in order.
REQ-036 Bench scenario: FIFO full with out_ready=1 and a new event on the same edge -> push accepted, occupancy stays 4, overflow stays 0.
REQ-037 Bench scenario: rst_n pulsed low with 3 entries queued and smp_en=1 -> all outputs are 0 immediately; after release, the first edge logs the current inputs with evt_cnt=1.
